load_align_ctrl: RTL

//  Sequences sub-word loads for the datapath: accepts a load request, issues one aligned

---
 rtl/load_pkg.sv | 26 ++
 rtl/load_extend.sv | 26 ++
 rtl/load_align_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - shared size encodings, FSM states and misalign helper for the load path
package load_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Size 2'b11 is treated as a word access everywhere.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - little-endian lane select with sign/zero extension
module load_extend
    import load_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word_i[{addr_lo_i, 3'b000} +: 8];
        // Half lane ignores addr[0]; misaligned halves read the lower-aligned lane.
        half_lane = word_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
            SZ_HALF: data_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_align_ctrl.sv
// rtl/load_align_ctrl.sv - sub-word load sequencer; MISALIGN_TRAP_EN turns misaligned half/word into error responses
module load_align_ctrl
    import load_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [1:0]    addr_lo_q, addr_lo_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_ready_q, req_ready_d;
    logic          mem_rd_en_q, mem_rd_en_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    logic          trap_hit;
    logic [CW-1:0] cnt_inc;
    logic          cnt_expired;
    logic [31:0]   ext_data;

`ifdef MISALIGN_TRAP_EN
    assign trap_hit = is_misaligned(req_addr[1:0], req_size);
`else
    assign trap_hit = 1'b0;
`endif

    assign cnt_inc     = cnt_q + CW'(1);
    assign cnt_expired = (cnt_inc == CNT_LAST);

    load_extend u_extend (
        .addr_lo_i  (addr_lo_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .word_i     (mem_rdata),
        .data_o     (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_lo_q   <= 2'b00;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = trap_hit ? RESP : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (mem_rvalid || cnt_expired) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; every output leaves a flop.
    always_comb begin
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        uns_d       = uns_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_lo_d   = req_addr[1:0];
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    req_ready_d = 1'b0;
                    if (trap_hit) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 32'h0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                    end
                end
            end
            ISSUE: begin
                cnt_d = '0;
            end
            WAIT: begin
                // Data arriving on the last counted cycle beats the timeout.
                if (mem_rvalid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = ext_data;
                    rsp_err_d   = 1'b0;
                end else if (cnt_expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 32'h0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign req_ready = req_ready_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule
